// File: rtl/cpu_top.sv
// Single-cycle RV32I integer execute datapath: decoder, 32x32 register file and ALU.
// Results and flags are combinational from the instruction and register state; writeback occurs on the rising clk edge.
module cpu_top (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] instruction,
  output logic [31:0] alu_result,
  output logic        zero_flag,
  output logic        eq_flag,
  output logic        less_flag,
  output logic        err_flag
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned RIDX  = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [XLEN-1:0] r_regs [NREGS];

  logic [6:0]      w_opcode;
  logic [RIDX-1:0] w_rd;
  logic [2:0]      w_funct3;
  logic [RIDX-1:0] w_rs1;
  logic [RIDX-1:0] w_rs2;
  logic [6:0]      w_funct7;
  logic [XLEN-1:0] w_imm;

  logic [3:0]      w_alu_op;
  logic            w_use_imm;
  logic            w_is_alu;
  logic            w_is_branch;
  logic            w_cmp_unsigned;
  logic            w_err;
  logic            w_wb_en;

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu_raw;
  logic            w_lt_signed;
  logic            w_lt_unsigned;

  assign w_opcode = instruction[6:0];
  assign w_rd     = instruction[11:7];
  assign w_funct3 = instruction[14:12];
  assign w_rs1    = instruction[19:15];
  assign w_rs2    = instruction[24:20];
  assign w_funct7 = instruction[31:25];
  assign w_imm    = {{20{instruction[31]}}, instruction[31:20]};

  // Decode opcode/funct fields into an ALU operation and legality
  always_comb begin
    w_alu_op       = ALU_ADD;
    w_use_imm      = 1'b0;
    w_is_alu       = 1'b0;
    w_is_branch    = 1'b0;
    w_cmp_unsigned = 1'b0;
    w_err          = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_is_alu = 1'b1;
        if (w_funct7 == F7_ZERO) begin
          case (w_funct3)
            3'd0:    w_alu_op = ALU_ADD;
            3'd1:    w_alu_op = ALU_SLL;
            3'd2:    w_alu_op = ALU_SLT;
            3'd3:    w_alu_op = ALU_SLTU;
            3'd4:    w_alu_op = ALU_XOR;
            3'd5:    w_alu_op = ALU_SRL;
            3'd6:    w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
          endcase
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'd0) begin
          w_alu_op = ALU_SUB;
        end else if (w_funct7 == F7_ALT && w_funct3 == 3'd5) begin
          w_alu_op = ALU_SRA;
        end else begin
          w_err = 1'b1;
        end
      end
      OP_I: begin
        w_is_alu  = 1'b1;
        w_use_imm = 1'b1;
        case (w_funct3)
          3'd0: w_alu_op = ALU_ADD;
          3'd1: begin
            w_alu_op = ALU_SLL;
            w_err    = (w_funct7 != F7_ZERO);
          end
          3'd2: w_alu_op = ALU_SLT;
          3'd3: w_alu_op = ALU_SLTU;
          3'd4: w_alu_op = ALU_XOR;
          3'd5: begin
            if (w_funct7 == F7_ZERO)     w_alu_op = ALU_SRL;
            else if (w_funct7 == F7_ALT) w_alu_op = ALU_SRA;
            else                         w_err    = 1'b1;
          end
          3'd6:    w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      OP_B: begin
        w_is_branch = 1'b1;
        case (w_funct3)
          3'd0, 3'd1, 3'd4, 3'd5: w_cmp_unsigned = 1'b0;
          3'd6, 3'd7:             w_cmp_unsigned = 1'b1;
          default:                w_err          = 1'b1;
        endcase
      end
      default: w_err = 1'b1;
    endcase
  end

  // Register reads: x0 is hardwired to zero, no write bypass
  assign w_op_a    = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];
  assign w_op_b    = w_use_imm ? w_imm : w_rs2_val;
  assign w_shamt   = w_op_b[4:0];

  assign w_lt_signed   = ($signed(w_op_a) < $signed(w_op_b));
  assign w_lt_unsigned = (w_op_a < w_op_b);

  always_comb begin
    w_alu_raw = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_raw = w_op_a + w_op_b;
      ALU_SUB:  w_alu_raw = w_op_a - w_op_b;
      ALU_SLL:  w_alu_raw = w_op_a << w_shamt;
      ALU_SLT:  w_alu_raw = XLEN'(w_lt_signed);
      ALU_SLTU: w_alu_raw = XLEN'(w_lt_unsigned);
      ALU_XOR:  w_alu_raw = w_op_a ^ w_op_b;
      ALU_SRL:  w_alu_raw = w_op_a >> w_shamt;
      ALU_SRA:  w_alu_raw = XLEN'($signed(w_op_a) >>> w_shamt);
      ALU_OR:   w_alu_raw = w_op_a | w_op_b;
      ALU_AND:  w_alu_raw = w_op_a & w_op_b;
      default:  w_alu_raw = '0;
    endcase
  end

  // Branches and illegal instructions force a zero result
  assign alu_result = (w_is_alu && !w_err) ? w_alu_raw : '0;
  assign zero_flag  = (alu_result == '0);
  assign eq_flag    = w_is_branch && !w_err && (w_op_a == w_op_b);
  assign less_flag  = w_is_branch && !w_err &&
                      (w_cmp_unsigned ? w_lt_unsigned : w_lt_signed);
  assign err_flag   = w_err;

  assign w_wb_en = w_is_alu && !w_err && (w_rd != '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_en) begin
      r_regs[w_rd] <= alu_result;
    end
  end

endmodule

// File: tb/tb_cpu_top.sv
// Directed self-checking bench for cpu_top: hand-computed RV32I vectors,
// register contents observed through "add x0, xN, x0" reads.
module tb_cpu_top;

  logic        clk;
  logic        nrst;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        eq_flag;
  logic        less_flag;
  logic        err_flag;

  int unsigned n_checks;
  int unsigned n_fail;

  cpu_top u_dut (
    .clk         (clk),
    .nrst        (nrst),
    .instruction (instruction),
    .alu_result  (alu_result),
    .zero_flag   (zero_flag),
    .eq_flag     (eq_flag),
    .less_flag   (less_flag),
    .err_flag    (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // add x0, xN, x0 : R-type with no writeback, result equals xN
  function automatic logic [31:0] rd_x(input int unsigned n);
    return 32'h0000_0033 | (32'(n) << 15);
  endfunction

  task automatic apply(input logic [31:0] ins);
    instruction = ins;
    #1;
  endtask

  task automatic chk_reg(input string tag, input int unsigned n, input logic [31:0] exp);
    apply(rd_x(n));
    chk(tag, alu_result, exp);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    nrst        = 1'b0;
    instruction = 32'h0000_0013;
    #12;
    nrst = 1'b1;
    #1;

    apply(32'h0091_1313);
    chk("rst_slli_res",  alu_result, 32'd0);
    chk("rst_slli_zero", 32'(zero_flag), 32'd1);
    chk("rst_slli_eq",   32'(eq_flag),   32'd0);
    chk("rst_slli_less", 32'(less_flag), 32'd0);
    chk("rst_slli_err",  32'(err_flag),  32'd0);

    apply(32'h0030_0113);
    chk("addi_x2", alu_result, 32'd3);
    tick();
    apply(32'h0091_1313);
    chk("slli_res",  alu_result, 32'd1536);
    chk("slli_zero", 32'(zero_flag), 32'd0);
    tick();

    apply(32'h4023_03B3);
    chk("sub_res", alu_result, 32'd1533);
    tick();
    apply(32'h0061_4063);
    chk("blt_res",  alu_result, 32'd0);
    chk("blt_zero", 32'(zero_flag), 32'd1);
    chk("blt_less", 32'(less_flag), 32'd1);
    chk("blt_eq",   32'(eq_flag),   32'd0);
    chk("blt_err",  32'(err_flag),  32'd0);
    tick();
    chk_reg("x2_after_blt", 2, 32'd3);
    chk_reg("x6_after_blt", 6, 32'd1536);
    chk_reg("x7_after_blt", 7, 32'd1533);

    apply(32'h0050_0013);
    chk("addi_x0_res", alu_result, 32'd5);
    tick();
    apply(32'h0000_0013);
    chk("x0_read", alu_result, 32'd0);

    apply(32'h0000_007F);
    chk("ill_err",  32'(err_flag),  32'd1);
    chk("ill_res",  alu_result,     32'd0);
    chk("ill_zero", 32'(zero_flag), 32'd1);
    tick();
    chk_reg("x2_after_ill", 2, 32'd3);
    chk_reg("x6_after_ill", 6, 32'd1536);

    // sub x8, x0, x2 -> -3, then signed/unsigned variants
    apply(32'h4020_0433);
    chk("sub_neg", alu_result, 32'hFFFF_FFFD);
    tick();
    apply(32'h4014_5493);
    chk("srai", alu_result, 32'hFFFF_FFFE);
    apply(32'h0024_3033);
    chk("sltu", alu_result, 32'd0);
    apply(32'h0024_2033);
    chk("slt", alu_result, 32'd1);
    apply(32'h0024_6063);
    chk("bltu_less", 32'(less_flag), 32'd0);
    apply(32'h0024_4063);
    chk("blt_neg_less", 32'(less_flag), 32'd1);
    apply(32'h0021_0063);
    chk("beq_eq",   32'(eq_flag),   32'd1);
    chk("beq_less", 32'(less_flag), 32'd0);
    apply(32'h0021_2063);
    chk("br_f3_2_err", 32'(err_flag), 32'd1);
    chk("br_f3_2_eq",  32'(eq_flag),  32'd0);
    apply(32'h4001_1313);
    chk("slli_bad_f7_err", 32'(err_flag), 32'd1);
    tick();
    chk_reg("x6_after_bad_slli", 6, 32'd1536);

    // asynchronous reset between edges, then an edge while held in reset
    chk_reg("x2_pre_reset", 2, 32'd3);
    nrst = 1'b0;
    #1;
    chk("x2_async_clear", alu_result, 32'd0);
    apply(32'h0030_0113);
    tick();
    chk_reg("x2_in_reset", 2, 32'd0);
    nrst = 1'b1;
    #1;
    chk_reg("x2_after_reset", 2, 32'd0);
    chk_reg("x6_after_reset", 6, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule

// File: doc/cpu_top.md
Name: cpu_top

Overview:
Single-cycle RV32I integer execute datapath: decoder, 32x32 register file and ALU. One 32-bit instruction is presented each cycle. The ALU result and flags are produced combinationally from the instruction and the current register state. The result is written back to rd on the rising clock edge. It is the top-level CPU integration block driven directly by the instruction source.

Parameters:
None. All widths are fixed: XLEN = 32, 32 registers.

Ports:
clk  input  1  system clock, rising-edge active
nrst  input  1  asynchronous, active-low reset
instruction  input  32  RV32I instruction word
alu_result  output  32  numerical/logical ALU output
zero_flag  output  1  high when alu_result == 0
eq_flag  output  1  branch ops: operands equal
less_flag  output  1  branch ops: rs1 < rs2 (signedness per op)
err_flag  output  1  unsupported or illegal instruction

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (nrst).
- Reset: nrst low immediately clears x1..x31 to 0, independent of clk. Reset wins over a simultaneous write.
- x0 is hardwired to 0. Reads of x0 return 0; writes to x0 are discarded.
- Outputs are purely combinational from instruction and register contents, so outputs have no reset value of their own. While in reset, operands read as 0.
- Decode fields: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- R-type (opcode 0110011), operands rs1 and rs2:
  - funct7 0000000 with funct3 0/1/2/3/4/5/6/7 = ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - funct7 0100000 with funct3 0 = SUB; with funct3 5 = SRA.
- I-type ALU (opcode 0010011), operands rs1 and sign-extended imm[31:20]:
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - SLLI requires funct7 = 0000000.
  - SRLI requires funct7 = 0000000; SRAI requires funct7 = 0100000.
- Branch (opcode 1100011), operands rs1 and rs2:
  - funct3 0/1/4/5/6/7 = BEQ/BNE/BLT/BGE/BLTU/BGEU; funct3 2 and 3 are illegal.
- Arithmetic rules:
  - Arithmetic wraps modulo 2^32.
  - Shift amount is operand B [4:0].
  - SRA/SRAI sign-fill.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 0 or 1.
- Branch ops:
  - alu_result = 0, so zero_flag = 1.
  - eq_flag = (rs1 == rs2).
  - less_flag = rs1 < rs2, signed for BLT/BGE and unsigned for BLTU/BGEU. BEQ/BNE use the signed compare.
  - No writeback.
- Non-branch ops: eq_flag = 0, less_flag = 0.
- Illegal instruction (any other opcode, or an illegal funct combination):
  - err_flag = 1, alu_result = 0, zero_flag = 1, eq_flag = 0, less_flag = 0.
  - No writeback.
- Writeback: on the rising clk edge with nrst high, a legal R-type or I-type instruction with rd != 0 writes regs[rd] <= alu_result. Latency is 1 cycle: a dependent instruction sees the new value after that edge.
- A read of a register being written in the same cycle returns the old value; there is no bypass.

Test Plan:
- Reset, then instruction 0x00911313 (slli x6,x2,9) -> alu_result 0, zero 1, eq 0, less 0, err 0.
- 0x00300113 (addi x2,x0,3), clock once, then 0x00911313 -> alu_result 1536, zero 0. Clock again so x6 = 1536.
- 0x402303B3 (sub x7,x6,x2) -> 1533. Then 0x00614063 (blt x2,x6) -> alu_result 0, zero 1, less 1, eq 0, no register change.
- 0x00500013 (addi x0,x0,5) -> alu_result 5. Clock, then read x0 via 0x00000013 -> 0.
- 0x0000007F -> err 1, result 0. Clock; all registers unchanged.
- Set x2 = 3, then pulse nrst low between edges -> x2 reads 0 immediately. A clk edge during reset writes nothing.
